// File: rtl/qam_mapper_pkg.sv
// Shared types, Q2.14 magnitude constants and helpers for the QAM mapper.
package qam_mapper_pkg;

   // Modulation mode as latched at the start of a symbol
   typedef enum logic [1:0] {
      QPSK    = 2'b00,
      QAM16   = 2'b01,
      QAM64   = 2'b10,
      ILLEGAL = 2'b11
   } mod_e;

   // Symbol collection state: no partial symbol / partial symbol held
   typedef enum logic {
      S_IDLE,
      S_COLLECT
   } col_e;

   // Output register occupancy
   typedef enum logic {
      O_EMPTY,
      O_FULL
   } out_e;

   localparam int unsigned MAG_W = 16;

   // Q2.14 magnitudes
   localparam logic [MAG_W-1:0] MAG_QPSK  = 16'h2D41; // 1/sqrt(2)
   localparam logic [MAG_W-1:0] MAG16_1   = 16'h143D; // 1/sqrt(10)
   localparam logic [MAG_W-1:0] MAG16_3   = 16'h3CB7; // 3/sqrt(10)
   localparam logic [MAG_W-1:0] MAG64_1   = 16'h09E0; // 1/sqrt(42)
   localparam logic [MAG_W-1:0] MAG64_3   = 16'h1DA0; // 3/sqrt(42)
   localparam logic [MAG_W-1:0] MAG64_5   = 16'h3161; // 5/sqrt(42)
   localparam logic [MAG_W-1:0] MAG64_7   = 16'h4521; // 7/sqrt(42)

   // Bits per symbol; an illegal mode is carried as QPSK
   function automatic logic [2:0] bits_per_sym(input mod_e m);
      logic [2:0] k;
      case (m)
         QAM16:   k = 3'd4;
         QAM64:   k = 3'd6;
         default: k = 3'd2;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/qam_level_lut.sv
// Maps (mode, {sign, m1, m0}) to a signed, left-aligned Q2.(DATA_W-2) level.
module qam_level_lut
   import qam_mapper_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  mod_e                      i_mode,
   input  logic [2:0]                i_half,
   output logic signed [DATA_W-1:0]  o_level
);

   logic [MAG_W-1:0]  w_mag;
   logic [DATA_W-1:0] w_mag_ext;

   // Gray-coded magnitude select, left-align to DATA_W, then apply sign
   always_comb begin
      w_mag = MAG_QPSK;
      case (i_mode)
         QAM16: w_mag = i_half[1] ? MAG16_3 : MAG16_1;
         QAM64: begin
            case (i_half[1:0])
               2'b01:   w_mag = MAG64_1;
               2'b00:   w_mag = MAG64_3;
               2'b10:   w_mag = MAG64_5;
               default: w_mag = MAG64_7;
            endcase
         end
         default: w_mag = MAG_QPSK;
      endcase
      w_mag_ext = DATA_W'(w_mag) << (DATA_W - MAG_W);
      o_level   = i_half[2] ? -w_mag_ext : w_mag_ext;
   end

endmodule

// File: rtl/qam_mapper_mod.sv
// Multi-mode (QPSK / 16-QAM / 64-QAM) serial-bit to I/Q constellation mapper
// with valid/ready handshakes on both sides and block-end marking.
// Optional feature macro: QAM_MAPPER_64QAM_EN enables 64-QAM on mod_sel=10;
// without it mod_sel=10 is illegal and the collection register is 4 bits.
module qam_mapper_mod
   import qam_mapper_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned BLK_BITS = 192
) (
   input  logic              clk_100,
   input  logic              Reset_N,
   input  logic [1:0]        mod_sel,
   input  logic              data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [DATA_W-1:0] I_comp,
   output logic [DATA_W-1:0] Q_comp,
   output logic              valid_out,
   input  logic              ready_in,
   output logic              sym_last,
   output logic              mode_err
);

`ifdef QAM_MAPPER_64QAM_EN
   localparam int unsigned SR_W = 6;
`else
   localparam int unsigned SR_W = 4;
`endif
   localparam int unsigned BLK_CNT_W = (BLK_BITS > 1) ? $clog2(BLK_BITS) : 1;
   localparam logic [BLK_CNT_W-1:0] BLK_LAST = BLK_CNT_W'(BLK_BITS - 1);

   // The last bit of a symbol is taken straight from data_in, so only
   // SR_W-1 earlier bits need storage.
   col_e                  r_state,  w_state_nxt;
   logic [2:0]            r_cnt,    w_cnt_nxt;
   logic [SR_W-2:0]       r_shift,  w_shift_nxt;
   mod_e                  r_mode,   w_mode_nxt;
   logic [BLK_CNT_W-1:0]  r_blk,    w_blk_nxt;
   out_e                  r_out_st, w_out_nxt;
   logic [DATA_W-1:0]     r_i,      w_i_nxt;
   logic [DATA_W-1:0]     r_q,      w_q_nxt;
   logic                  r_last,   w_last_nxt;
   logic                  r_err,    w_err_nxt;

   logic                  w_accept;
   mod_e                  w_mode_sel;
   mod_e                  w_mode_cur;
   logic [2:0]            w_k;
   logic [5:0]            w_sym;
   logic [2:0]            w_i_half;
   logic [2:0]            w_q_half;
   logic signed [DATA_W-1:0] w_i_lvl;
   logic signed [DATA_W-1:0] w_q_lvl;

   assign valid_out = (r_out_st == O_FULL);
   assign ready_out = Reset_N && (!valid_out || ready_in);
   assign I_comp    = r_i;
   assign Q_comp    = r_q;
   assign sym_last  = r_last;
   assign mode_err  = r_err;
   assign w_accept  = valid_in && ready_out;

   // Decode mod_sel; 64-QAM is only legal when the feature is built in
   always_comb begin
      w_mode_sel = mod_e'(mod_sel);
`ifndef QAM_MAPPER_64QAM_EN
      if (mod_sel == 2'b10) w_mode_sel = ILLEGAL;
`endif
   end

   // Mode for the bit being accepted: fresh on a symbol's first bit, else latched
   assign w_mode_cur = (r_state == S_IDLE) ? w_mode_sel : r_mode;
   assign w_k        = bits_per_sym(w_mode_cur);
   assign w_sym      = 6'({r_shift, data_in});

   // Split the completed symbol into I and Q halves as {sign, m1, m0}
   always_comb begin
      w_i_half = {w_sym[1], 2'b00};
      w_q_half = {w_sym[0], 2'b00};
      case (w_mode_cur)
         QAM16: begin
            w_i_half = {w_sym[3], w_sym[2], 1'b0};
            w_q_half = {w_sym[1], w_sym[0], 1'b0};
         end
         QAM64: begin
            w_i_half = w_sym[5:3];
            w_q_half = w_sym[2:0];
         end
         default: begin
            w_i_half = {w_sym[1], 2'b00};
            w_q_half = {w_sym[0], 2'b00};
         end
      endcase
   end

   qam_level_lut #(.DATA_W(DATA_W)) u_lut_i (
      .i_mode  (w_mode_cur),
      .i_half  (w_i_half),
      .o_level (w_i_lvl)
   );

   qam_level_lut #(.DATA_W(DATA_W)) u_lut_q (
      .i_mode  (w_mode_cur),
      .i_half  (w_q_half),
      .o_level (w_q_lvl)
   );

   // Next-state: collect bits, latch mode, count block bits, load/drain output
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_mode_nxt  = r_mode;
      w_blk_nxt   = r_blk;
      w_out_nxt   = r_out_st;
      w_i_nxt     = r_i;
      w_q_nxt     = r_q;
      w_last_nxt  = r_last;
      w_err_nxt   = 1'b0;

      if (ready_in) w_out_nxt = O_EMPTY;

      if (w_accept) begin
         w_shift_nxt = {r_shift[SR_W-3:0], data_in};
         w_blk_nxt   = (r_blk == BLK_LAST) ? '0 : r_blk + 1'b1;
         if (r_state == S_IDLE) begin
            w_mode_nxt = w_mode_cur;
            w_err_nxt  = (w_mode_cur == ILLEGAL);
         end
         if ((r_cnt + 3'd1) == w_k) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
            w_out_nxt   = O_FULL;
            w_i_nxt     = w_i_lvl;
            w_q_nxt     = w_q_lvl;
            w_last_nxt  = (r_blk == BLK_LAST);
         end else begin
            w_state_nxt = S_COLLECT;
            w_cnt_nxt   = r_cnt + 3'd1;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk_100 or negedge Reset_N) begin
      if (!Reset_N) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_shift  <= '0;
         r_mode   <= QPSK;
         r_blk    <= '0;
         r_out_st <= O_EMPTY;
         r_i      <= '0;
         r_q      <= '0;
         r_last   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_shift  <= w_shift_nxt;
         r_mode   <= w_mode_nxt;
         r_blk    <= w_blk_nxt;
         r_out_st <= w_out_nxt;
         r_i      <= w_i_nxt;
         r_q      <= w_q_nxt;
         r_last   <= w_last_nxt;
         r_err    <= w_err_nxt;
      end
   end

endmodule

// File: tb/tb_qam_mapper_mod.sv
// Directed, table-driven bench for qam_mapper_mod (DATA_W=16, BLK_BITS=192).
// Expected 64-QAM results depend on QAM_MAPPER_64QAM_EN.
module tb_qam_mapper_mod;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned BLK_BITS = 192;

   logic              clk_100;
   logic              Reset_N;
   logic [1:0]        mod_sel;
   logic              data_in;
   logic              valid_in;
   logic              ready_out;
   logic [DATA_W-1:0] I_comp;
   logic [DATA_W-1:0] Q_comp;
   logic              valid_out;
   logic              ready_in;
   logic              sym_last;
   logic              mode_err;

   int n_checks;
   int n_fail;

   qam_mapper_mod #(.DATA_W(DATA_W), .BLK_BITS(BLK_BITS)) dut (
      .clk_100   (clk_100),
      .Reset_N   (Reset_N),
      .mod_sel   (mod_sel),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .I_comp    (I_comp),
      .Q_comp    (Q_comp),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .sym_last  (sym_last),
      .mode_err  (mode_err)
   );

   initial clk_100 = 1'b0;
   always #5 clk_100 = ~clk_100;

   typedef struct {
      logic [1:0]  sel;
      int          nb;
      logic [5:0]  bits;   // first bit sent is bits[5]
      logic [15:0] ei;
      logic [15:0] eq;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [1:0] sel, input int nb, input logic [5:0] bits,
                               input logic [15:0] ei, input logic [15:0] eq, input logic err);
      vec_t v;
      v.sel = sel; v.nb = nb; v.bits = bits; v.ei = ei; v.eq = eq; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge; return just after the rising edge
   task automatic step(input logic v, input logic d, input logic [1:0] sel);
      @(negedge clk_100);
      valid_in = v;
      data_in  = d;
      mod_sel  = sel;
      @(posedge clk_100);
      #1;
   endtask

   task automatic do_reset(input bit check_now);
      @(negedge clk_100);
      Reset_N  = 1'b0;
      valid_in = 1'b0;
      #1;
      if (check_now) begin
         chk("rst_I",         32'(I_comp),    32'h0);
         chk("rst_Q",         32'(Q_comp),    32'h0);
         chk("rst_valid_out", 32'(valid_out), 32'h0);
         chk("rst_sym_last",  32'(sym_last),  32'h0);
         chk("rst_mode_err",  32'(mode_err),  32'h0);
         chk("rst_ready_out", 32'(ready_out), 32'h0);
      end
      repeat (2) @(negedge clk_100);
      Reset_N = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Reset_N  = 1'b0;
      mod_sel  = 2'b00;
      data_in  = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;

      vecs.push_back(mk(2'b00, 2, 6'b010000, 16'h2D41, 16'hD2BF, 1'b0));
      vecs.push_back(mk(2'b00, 2, 6'b100000, 16'hD2BF, 16'h2D41, 1'b0));
      vecs.push_back(mk(2'b00, 2, 6'b110000, 16'hD2BF, 16'hD2BF, 1'b0));
      vecs.push_back(mk(2'b01, 4, 6'b110000, 16'hC349, 16'h143D, 1'b0));
      vecs.push_back(mk(2'b01, 4, 6'b001100, 16'h143D, 16'hC349, 1'b0));
      vecs.push_back(mk(2'b01, 4, 6'b011000, 16'h3CB7, 16'hEBC3, 1'b0));
`ifdef QAM_MAPPER_64QAM_EN
      vecs.push_back(mk(2'b10, 6, 6'b011101, 16'h4521, 16'hF620, 1'b0));
      vecs.push_back(mk(2'b10, 6, 6'b100010, 16'hE260, 16'h3161, 1'b0));
      vecs.push_back(mk(2'b10, 6, 6'b111001, 16'hBADF, 16'h09E0, 1'b0));
`else
      // 0,1,1,1,0,1 on mod_sel=10 becomes three QPSK symbols, each flagged
      vecs.push_back(mk(2'b10, 2, 6'b010000, 16'h2D41, 16'hD2BF, 1'b1));
      vecs.push_back(mk(2'b10, 2, 6'b110000, 16'hD2BF, 16'hD2BF, 1'b1));
      vecs.push_back(mk(2'b10, 2, 6'b010000, 16'h2D41, 16'hD2BF, 1'b1));
`endif
      vecs.push_back(mk(2'b11, 2, 6'b000000, 16'h2D41, 16'h2D41, 1'b1));
      vecs.push_back(mk(2'b11, 2, 6'b100000, 16'hD2BF, 16'h2D41, 1'b1));

      do_reset(1'b1);

      // Table: symbols back-to-back with ready_in high
      for (int n = 0; n < vecs.size(); n++) begin
         for (int j = 0; j < vecs[n].nb; j++) begin
            step(1'b1, vecs[n].bits[5-j], vecs[n].sel);
            if (j == 0) begin
               chk($sformatf("vec%0d_mode_err", n), 32'(mode_err),  32'(vecs[n].err));
               chk($sformatf("vec%0d_busy", n),     32'(valid_out), 32'h0);
            end
         end
         chk($sformatf("vec%0d_valid", n),   32'(valid_out), 32'h1);
         chk($sformatf("vec%0d_I", n),       32'(I_comp),    32'(vecs[n].ei));
         chk($sformatf("vec%0d_Q", n),       32'(Q_comp),    32'(vecs[n].eq));
         chk($sformatf("vec%0d_last", n),    32'(sym_last),  32'h0);
         chk($sformatf("vec%0d_err_clr", n), 32'(mode_err),  32'h0);
      end
      step(1'b0, 1'b0, 2'b00);
      chk("drain_valid", 32'(valid_out), 32'h0);

      // Partial symbol held while valid_in is low, mod_sel changes ignored
      step(1'b1, 1'b0, 2'b00);
      repeat (4) step(1'b0, 1'b1, 2'b11);
      chk("hold_valid", 32'(valid_out), 32'h0);
      step(1'b1, 1'b1, 2'b01);
      chk("hold_sym_valid", 32'(valid_out), 32'h1);
      chk("hold_I",         32'(I_comp),    32'h2D41);
      chk("hold_Q",         32'(Q_comp),    32'hD2BF);
      step(1'b0, 1'b0, 2'b00);

      // Backpressure: full output register stalled for 5 cycles
      ready_in = 1'b0;
      step(1'b1, 1'b0, 2'b00);
      step(1'b1, 1'b1, 2'b00);
      chk("bp_load_valid", 32'(valid_out), 32'h1);
      for (int c = 0; c < 5; c++) begin
         step(1'b1, 1'b1, 2'b00);
         chk($sformatf("bp%0d_ready_out", c), 32'(ready_out), 32'h0);
         chk($sformatf("bp%0d_valid", c),     32'(valid_out), 32'h1);
         chk($sformatf("bp%0d_I", c),         32'(I_comp),    32'h2D41);
         chk($sformatf("bp%0d_Q", c),         32'(Q_comp),    32'hD2BF);
      end
      ready_in = 1'b1;
      step(1'b1, 1'b1, 2'b00);
      chk("bp_rel_valid", 32'(valid_out), 32'h0);
      step(1'b1, 1'b1, 2'b00);
      chk("bp_next_valid", 32'(valid_out), 32'h1);
      chk("bp_next_I",     32'(I_comp),    32'hD2BF);
      chk("bp_next_Q",     32'(Q_comp),    32'hD2BF);
      step(1'b0, 1'b0, 2'b00);

      // mod_sel toggled mid-symbol is ignored (16-QAM 1,1,0,0)
      step(1'b1, 1'b1, 2'b01);
      chk("tog_err0", 32'(mode_err), 32'h0);
      step(1'b1, 1'b1, 2'b00);
      step(1'b1, 1'b0, 2'b11);
      chk("tog_err2", 32'(mode_err), 32'h0);
      step(1'b1, 1'b0, 2'b10);
      chk("tog_valid", 32'(valid_out), 32'h1);
      chk("tog_I",     32'(I_comp),    32'hC349);
      chk("tog_Q",     32'(Q_comp),    32'h143D);
      chk("tog_err3",  32'(mode_err),  32'h0);

      // Reset after 3 of 4 bits discards the partial symbol
      step(1'b1, 1'b1, 2'b01);
      step(1'b1, 1'b0, 2'b01);
      step(1'b1, 1'b1, 2'b01);
      do_reset(1'b1);
      step(1'b1, 1'b0, 2'b01);
      chk("post_rst_b0_valid", 32'(valid_out), 32'h0);
      step(1'b1, 1'b1, 2'b01);
      step(1'b1, 1'b1, 2'b01);
      chk("post_rst_b2_valid", 32'(valid_out), 32'h0);
      step(1'b1, 1'b0, 2'b01);
      chk("post_rst_valid", 32'(valid_out), 32'h1);
      chk("post_rst_I",     32'(I_comp),    32'h3CB7);
      chk("post_rst_Q",     32'(Q_comp),    32'hEBC3);
      step(1'b0, 1'b0, 2'b00);

      // Two QPSK blocks from a fresh reset: sym_last on symbols 95 and 191 only
      do_reset(1'b0);
      for (int s = 0; s < 2 * BLK_BITS / 2; s++) begin
         step(1'b1, s[0], 2'b00);
         step(1'b1, s[1], 2'b00);
         chk($sformatf("blk_s%0d_valid", s), 32'(valid_out), 32'h1);
         chk($sformatf("blk_s%0d_last", s),  32'(sym_last),
             ((s % (BLK_BITS / 2)) == (BLK_BITS / 2 - 1)) ? 32'h1 : 32'h0);
      end
      step(1'b0, 1'b0, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
